clock_setter: RTL and testbench
===============================

Name: clock_setter

Overview:
- Button-driven front-end that writes the clock block's set and alarm interface.
- Converts debounced mode/inc/dec/alarm/snooze buttons into the set pulse with setMin/setHr/setPm, plus alarm, alarmMin/alarmHr/alarmPm.
- Reads the running time (minutes/hours/pm) and alarmSound back from the clock to seed edits and handle snooze.
- Sits between the board buttons and the clock instance.

Parameters:
SNOOZE_MIN, 9, minutes added to alarm time on snooze; legal 1..59.
RESET_HR, 12, hour value loaded into setHr/alarmHr on reset; legal 1..12.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
mode_btn  in  1  debounced level; rising edge advances edit field.
inc_btn  in  1  debounced level; rising edge increments current field.
dec_btn  in  1  debounced level; rising edge decrements current field.
alarm_btn  in  1  debounced level; rising edge toggles alarm enable (IDLE only).
snooze_btn  in  1  debounced level; rising edge snoozes a sounding alarm.
cur_minutes  in  6  running minutes from clock, 0..59.
cur_hours  in  4  running hours from clock, 1..12.
cur_pm  in  1  running AM/PM from clock.
alarm_sound  in  1  alarmSound from clock.
set  out  1  one-cycle pulse committing setMin/setHr/setPm.
setMin  out  6  committed minutes, held stable.
setHr  out  4  committed hours, held stable.
setPm  out  1  committed AM/PM, held stable.
alarm  out  1  alarm enable level to clock.
alarmMin  out  6  alarm minutes.
alarmHr  out  4  alarm hours.
alarmPm  out  1  alarm AM/PM.
editing  out  1  high in any non-IDLE state.
edit_field  out  3  current state encoding: 0 IDLE, 1 T_HR, 2 T_MIN, 3 T_PM, 4 A_HR, 5 A_MIN, 6 A_PM.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Reset values: set=0, setMin=0, setHr=RESET_HR, setPm=0, alarm=0, alarm_en=0, alarmMin=0, alarmHr=RESET_HR, alarmPm=0, state IDLE, editing=0, edit_field=0.
- Edge detect: one prev register per button. During reset, each prev register loads the live button level, so a button held through reset produces no edge.
- Latency: an edge sampled at posedge N is acted on at N; resulting outputs are visible after posedge N.
- FSM on mode edge:
  - IDLE->T_HR: load edit regs from cur_*.
  - T_HR->T_MIN->T_PM.
  - T_PM->A_HR: assert set for exactly 1 cycle with setMin/setHr/setPm = edit regs; load edit regs from alarm regs.
  - A_HR->A_MIN->A_PM.
  - A_PM->IDLE: write edit regs to alarmMin/alarmHr/alarmPm.
- Field arithmetic:
  - Hours: inc 12->1, dec 1->12.
  - Minutes: inc 59->0, dec 0->59.
  - PM: inc or dec toggles.
  - No carry between fields during edit.
- Simultaneous events:
  - inc and dec in the same cycle: no change.
  - mode with inc/dec in the same cycle: mode wins, inc/dec discarded.
  - inc/dec in IDLE: ignored.
- alarm output:
  - IDLE: alarm = alarm_en.
  - A_HR..A_PM: alarm forced 0, so no match against a half-edited time; alarm_en restored on return to IDLE.
  - T_*: alarm = alarm_en.
- alarm_btn:
  - In IDLE: toggles alarm_en. Clearing it drops alarm, which silences the clock.
  - Outside IDLE: ignored.
- Reset mid-edit: return to IDLE immediately, no set pulse, alarm regs untouched by the partial edit (reset values apply).
- setMin/setHr/setPm change only on the commit cycle.

Optional Feature:
CLOCK_SETTER_SNOOZE_EN
- Defined, snooze_btn edge while alarm_sound=1, alarm_en=1, state IDLE:
  - alarm driven 0 for exactly 1 cycle; the clock clears alarmSound on that falling edge.
  - Same cycle, alarm time advances by SNOOZE_MIN: min+SNOOZE_MIN; if >=60, subtract 60 and hour+1.
  - Hour 12->1. Hour 11->12 toggles alarmPm.
  - alarm returns to 1 on the next cycle.
- Defined, snooze with alarm_sound=0 or not in IDLE: ignored.
- Not defined: snooze_btn ignored entirely; no snooze logic synthesized.

Test Plan:
- Reset, cur time 9:45 AM; mode, inc, mode, 15x inc, mode, inc, mode -> set high 1 cycle with setHr=10, setMin=0, setPm=1; edit_field=4.
- T_HR at 12, inc -> 1; dec -> 12; inc+dec same cycle -> stays 12; T_MIN at 0, dec -> 59.
- Alarm edit 6:30 AM via A_* fields, mode to IDLE, alarm_btn -> alarm=1, alarmHr=6, alarmMin=30, alarmPm=0; re-enter A_HR -> alarm=0 until IDLE.
- SNOOZE_EN: alarm 11:55 AM, alarm_en=1, alarm_sound=1, snooze -> alarm 0 for 1 cycle then 1; alarmHr=12, alarmMin=4, alarmPm=1.
- mode held; reset asserted in T_MIN, released with mode still high -> IDLE, no set pulse, no spurious edge, all outputs at reset values.
- Without SNOOZE_EN: alarm_sound=1, snooze edge -> alarm stays 1, alarm regs unchanged.

Source files
------------

// File: rtl/clock_setter_if.sv
// clock_setter_if: bundles the button inputs, clock readback and set/alarm
//    outputs of clock_setter into one port.
// Latency: n/a (wires only). Backpressure: none; all signals are plain levels/pulses.
// Ports (slave = clock_setter side):
//    in : mode_btn, inc_btn, dec_btn, alarm_btn, snooze_btn (debounced levels),
//         cur_minutes/cur_hours/cur_pm, alarm_sound (readback from clock)
//    out: set, setMin/setHr/setPm, alarm, alarmMin/alarmHr/alarmPm,
//         editing, edit_field
interface clock_setter_if;
   logic       mode_btn;
   logic       inc_btn;
   logic       dec_btn;
   logic       alarm_btn;
   logic       snooze_btn;
   logic [5:0] cur_minutes;
   logic [3:0] cur_hours;
   logic       cur_pm;
   logic       alarm_sound;
   logic       set;
   logic [5:0] setMin;
   logic [3:0] setHr;
   logic       setPm;
   logic       alarm;
   logic [5:0] alarmMin;
   logic [3:0] alarmHr;
   logic       alarmPm;
   logic       editing;
   logic [2:0] edit_field;

   // master: board/clock side driving buttons and readback
   modport master (
      output mode_btn, inc_btn, dec_btn, alarm_btn, snooze_btn,
             cur_minutes, cur_hours, cur_pm, alarm_sound,
      input  set, setMin, setHr, setPm, alarm, alarmMin, alarmHr, alarmPm,
             editing, edit_field
   );

   // slave: clock_setter itself
   modport slave (
      input  mode_btn, inc_btn, dec_btn, alarm_btn, snooze_btn,
             cur_minutes, cur_hours, cur_pm, alarm_sound,
      output set, setMin, setHr, setPm, alarm, alarmMin, alarmHr, alarmPm,
             editing, edit_field
   );
endinterface

// File: rtl/clock_setter.sv
// clock_setter: button-driven editor that writes the clock's set and alarm time.
// Latency: a button edge sampled at posedge N updates state/outputs after posedge N.
// Backpressure: none; every edge is consumed in the cycle it is seen.
// Ports: clk, reset (sync, active-high), cs (clock_setter_if.slave: buttons,
//    cur_* readback, alarm_sound in; set/setMin/setHr/setPm, alarm/alarm*,
//    editing, edit_field out).
// Optional: define CLOCK_SETTER_SNOOZE_EN to enable the snooze button.
module clock_setter #(
   parameter int SNOOZE_MIN = 9,
   parameter int RESET_HR   = 12
) (
   input  logic          clk,
   input  logic          reset,
   clock_setter_if.slave cs
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      T_HR  = 3'd1,
      T_MIN = 3'd2,
      T_PM  = 3'd3,
      A_HR  = 3'd4,
      A_MIN = 3'd5,
      A_PM  = 3'd6
   } state_t;

   state_t     state, nextState;
   logic       modePrev, incPrev, decPrev, alarmPrev;
   logic       modeEdge, incEdge, decEdge, alarmEdge;
   logic       incOnly, decOnly;
   logic [5:0] editMin, editMinN;
   logic [3:0] editHr, editHrN;
   logic       editPm, editPmN;
   logic       setReg, setRegN;
   logic [5:0] setMinReg, setMinN;
   logic [3:0] setHrReg, setHrN;
   logic       setPmReg, setPmN;
   logic       alarmEn, alarmEnN;
   logic [5:0] aMin, aMinN;
   logic [3:0] aHr, aHrN;
   logic       aPm, aPmN;
   logic       inAlarmEdit;

`ifdef CLOCK_SETTER_SNOOZE_EN
   logic       snoozePrev, snoozeEdge;
   logic       snoozeGap, snoozeGapN;
   logic [6:0] minSum;
`else
   logic       unusedIn;
   assign unusedIn = ^{cs.snooze_btn, cs.alarm_sound, 6'(SNOOZE_MIN)};
`endif

   function automatic logic [3:0] hrInc(input logic [3:0] h);
      return (h >= 4'd12) ? 4'd1 : h + 4'd1;
   endfunction
   function automatic logic [3:0] hrDec(input logic [3:0] h);
      return (h <= 4'd1) ? 4'd12 : h - 4'd1;
   endfunction
   function automatic logic [5:0] minInc(input logic [5:0] m);
      return (m >= 6'd59) ? 6'd0 : m + 6'd1;
   endfunction
   function automatic logic [5:0] minDec(input logic [5:0] m);
      return (m == 6'd0) ? 6'd59 : m - 6'd1;
   endfunction

   assign modeEdge  = cs.mode_btn  & ~modePrev;
   assign incEdge   = cs.inc_btn   & ~incPrev;
   assign decEdge   = cs.dec_btn   & ~decPrev;
   assign alarmEdge = cs.alarm_btn & ~alarmPrev;
   // inc and dec together cancel out
   assign incOnly   = incEdge & ~decEdge;
   assign decOnly   = decEdge & ~incEdge;
`ifdef CLOCK_SETTER_SNOOZE_EN
   assign snoozeEdge = cs.snooze_btn & ~snoozePrev;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         // prev regs track the live level so a button held through reset gives no edge
         modePrev  <= cs.mode_btn;
         incPrev   <= cs.inc_btn;
         decPrev   <= cs.dec_btn;
         alarmPrev <= cs.alarm_btn;
         editMin   <= 6'd0;
         editHr    <= 4'(RESET_HR);
         editPm    <= 1'b0;
         setReg    <= 1'b0;
         setMinReg <= 6'd0;
         setHrReg  <= 4'(RESET_HR);
         setPmReg  <= 1'b0;
         alarmEn   <= 1'b0;
         aMin      <= 6'd0;
         aHr       <= 4'(RESET_HR);
         aPm       <= 1'b0;
`ifdef CLOCK_SETTER_SNOOZE_EN
         snoozePrev <= cs.snooze_btn;
         snoozeGap  <= 1'b0;
`endif
      end else begin
         state     <= nextState;
         modePrev  <= cs.mode_btn;
         incPrev   <= cs.inc_btn;
         decPrev   <= cs.dec_btn;
         alarmPrev <= cs.alarm_btn;
         editMin   <= editMinN;
         editHr    <= editHrN;
         editPm    <= editPmN;
         setReg    <= setRegN;
         setMinReg <= setMinN;
         setHrReg  <= setHrN;
         setPmReg  <= setPmN;
         alarmEn   <= alarmEnN;
         aMin      <= aMinN;
         aHr       <= aHrN;
         aPm       <= aPmN;
`ifdef CLOCK_SETTER_SNOOZE_EN
         snoozePrev <= cs.snooze_btn;
         snoozeGap  <= snoozeGapN;
`endif
      end
   end

   always_comb begin
      nextState = state;
      editMinN  = editMin;
      editHrN   = editHr;
      editPmN   = editPm;
      setRegN   = 1'b0;
      setMinN   = setMinReg;
      setHrN    = setHrReg;
      setPmN    = setPmReg;
      alarmEnN  = alarmEn;
      aMinN     = aMin;
      aHrN      = aHr;
      aPmN      = aPm;
`ifdef CLOCK_SETTER_SNOOZE_EN
      snoozeGapN = 1'b0;
      minSum     = {1'b0, aMin} + 7'(SNOOZE_MIN);
`endif
      case (state)
         IDLE: begin
            if (modeEdge) begin
               nextState = T_HR;
               editMinN  = cs.cur_minutes;
               editHrN   = cs.cur_hours;
               editPmN   = cs.cur_pm;
            end
            if (alarmEdge)
               alarmEnN = ~alarmEn;
`ifdef CLOCK_SETTER_SNOOZE_EN
            // One-cycle low on alarm lets the clock clear alarmSound; the
            // alarm time moves forward so it matches again later.
            if (snoozeEdge && cs.alarm_sound && alarmEn) begin
               snoozeGapN = 1'b1;
               if (minSum >= 7'd60) begin
                  aMinN = 6'(minSum - 7'd60);
                  if (aHr == 4'd11) begin
                     aHrN = 4'd12;
                     aPmN = ~aPm;
                  end else begin
                     aHrN = hrInc(aHr);
                  end
               end else begin
                  aMinN = minSum[5:0];
               end
            end
`endif
         end
         T_HR: begin
            if (modeEdge)     nextState = T_MIN;
            else if (incOnly) editHrN = hrInc(editHr);
            else if (decOnly) editHrN = hrDec(editHr);
         end
         T_MIN: begin
            if (modeEdge)     nextState = T_PM;
            else if (incOnly) editMinN = minInc(editMin);
            else if (decOnly) editMinN = minDec(editMin);
         end
         T_PM: begin
            if (modeEdge) begin
               nextState = A_HR;
               setRegN   = 1'b1;
               setMinN   = editMin;
               setHrN    = editHr;
               setPmN    = editPm;
               editMinN  = aMin;
               editHrN   = aHr;
               editPmN   = aPm;
            end else if (incOnly || decOnly) begin
               editPmN = ~editPm;
            end
         end
         A_HR: begin
            if (modeEdge)     nextState = A_MIN;
            else if (incOnly) editHrN = hrInc(editHr);
            else if (decOnly) editHrN = hrDec(editHr);
         end
         A_MIN: begin
            if (modeEdge)     nextState = A_PM;
            else if (incOnly) editMinN = minInc(editMin);
            else if (decOnly) editMinN = minDec(editMin);
         end
         A_PM: begin
            if (modeEdge) begin
               nextState = IDLE;
               aMinN     = editMin;
               aHrN      = editHr;
               aPmN      = editPm;
            end else if (incOnly || decOnly) begin
               editPmN = ~editPm;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Alarm is masked while the alarm time is half-edited so the clock never
   // matches against an intermediate value.
   assign inAlarmEdit = (state == A_HR) || (state == A_MIN) || (state == A_PM);

`ifdef CLOCK_SETTER_SNOOZE_EN
   assign cs.alarm = alarmEn & ~inAlarmEdit & ~snoozeGap;
`else
   assign cs.alarm = alarmEn & ~inAlarmEdit;
`endif
   assign cs.set        = setReg;
   assign cs.setMin     = setMinReg;
   assign cs.setHr      = setHrReg;
   assign cs.setPm      = setPmReg;
   assign cs.alarmMin   = aMin;
   assign cs.alarmHr    = aHr;
   assign cs.alarmPm    = aPm;
   assign cs.editing    = (state != IDLE);
   assign cs.edit_field = state;

endmodule

// File: tb/tb_clock_setter.sv
// tb_clock_setter: directed scoreboard bench for clock_setter.
// Latency: n/a. Backpressure: n/a.
// Stimulus pushes expected commits/snapshots into queues; a negedge monitor pops and compares.
module tb_clock_setter;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   clock_setter_if cs();
   clock_setter #(.SNOOZE_MIN(9), .RESET_HR(12)) dut (
      .clk  (clk),
      .reset(reset),
      .cs   (cs)
   );

   typedef struct {
      string      name;
      logic [2:0] field;
      logic       alarm;
      logic [3:0] aHr;
      logic [5:0] aMin;
      logic       aPm;
      logic [3:0] sHr;
      logic [5:0] sMin;
      logic       sPm;
   } snap_t;

   typedef struct packed {
      logic [3:0] hr;
      logic [5:0] mn;
      logic       pm;
   } commit_t;

   snap_t   sq[$];
   commit_t cq[$];
   snap_t   se;
   commit_t ce;
   int      errors = 0;
   int      checks = 0;
   bit      done = 1'b0;
   bit      lastSet = 1'b0;

   // hand-tracked expected register contents
   logic [3:0] eSHr = 4'd12, eAHr = 4'd12;
   logic [5:0] eSMin = 6'd0, eAMin = 6'd0;
   logic       eSPm = 1'b0, eAPm = 1'b0;

   task automatic snap(input string name, input logic [2:0] field, input logic alarm);
      snap_t s;
      s.name = name; s.field = field; s.alarm = alarm;
      s.aHr = eAHr; s.aMin = eAMin; s.aPm = eAPm;
      s.sHr = eSHr; s.sMin = eSMin; s.sPm = eSPm;
      sq.push_back(s);
   endtask

   task automatic commit(input logic [3:0] hr, input logic [5:0] mn, input logic pm);
      commit_t c;
      c.hr = hr; c.mn = mn; c.pm = pm;
      cq.push_back(c);
      eSHr = hr; eSMin = mn; eSPm = pm;
   endtask

   task automatic press(input bit m, input bit i, input bit d, input bit a);
      cs.mode_btn = m; cs.inc_btn = i; cs.dec_btn = d; cs.alarm_btn = a;
      @(posedge clk); #1;
      cs.mode_btn = 1'b0; cs.inc_btn = 1'b0; cs.dec_btn = 1'b0; cs.alarm_btn = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic pMode(input int n);
      for (int k = 0; k < n; k++) press(1, 0, 0, 0);
   endtask
   task automatic pInc(input int n);
      for (int k = 0; k < n; k++) press(0, 1, 0, 0);
   endtask
   task automatic pDec(input int n);
      for (int k = 0; k < n; k++) press(0, 0, 1, 0);
   endtask

   always @(negedge clk) begin
      if (cs.set) begin
         checks++;
         if (lastSet) begin
            errors++;
            $display("FAIL set_width: set high on consecutive cycles, required a 1-cycle pulse");
         end else if (cq.size() == 0) begin
            errors++;
            $display("FAIL set_unexpected: set=1 with no commit pending, required set=0");
         end else begin
            ce = cq.pop_front();
            if ({cs.setHr, cs.setMin, cs.setPm} !== {ce.hr, ce.mn, ce.pm}) begin
               errors++;
               $display("FAIL commit: got %0d:%0d pm=%0d, required %0d:%0d pm=%0d",
                        cs.setHr, cs.setMin, cs.setPm, ce.hr, ce.mn, ce.pm);
            end
         end
      end
      lastSet = cs.set;
      while (sq.size() > 0) begin
         se = sq.pop_front();
         checks++;
         if ({cs.edit_field, cs.editing, cs.alarm, cs.alarmHr, cs.alarmMin, cs.alarmPm,
              cs.setHr, cs.setMin, cs.setPm, cs.set} !==
             {se.field, (se.field != 3'd0), se.alarm, se.aHr, se.aMin, se.aPm,
              se.sHr, se.sMin, se.sPm, 1'b0}) begin
            errors++;
            $display("FAIL %s: got field=%0d ed=%0d alarm=%0d a=%0d:%0d pm%0d s=%0d:%0d pm%0d set=%0d, required field=%0d alarm=%0d a=%0d:%0d pm%0d s=%0d:%0d pm%0d set=0",
                     se.name, cs.edit_field, cs.editing, cs.alarm, cs.alarmHr, cs.alarmMin,
                     cs.alarmPm, cs.setHr, cs.setMin, cs.setPm, cs.set, se.field, se.alarm,
                     se.aHr, se.aMin, se.aPm, se.sHr, se.sMin, se.sPm);
         end
      end
      if (done) begin
         checks++;
         if (cq.size() != 0) begin
            errors++;
            $display("FAIL commit_missing: %0d commits never pulsed, required 0", cq.size());
         end
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      cs.mode_btn = 0; cs.inc_btn = 0; cs.dec_btn = 0; cs.alarm_btn = 0; cs.snooze_btn = 0;
      cs.cur_hours = 4'd9; cs.cur_minutes = 6'd45; cs.cur_pm = 1'b0; cs.alarm_sound = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      snap("reset", 0, 0);

      // time edit from 9:45 AM -> 10:00 PM, minutes wrap 59->0
      pMode(1); pInc(1); pMode(1); pInc(15); pMode(1); pInc(1);
      commit(10, 0, 1);
      pMode(1);
      snap("commit1", 4, 0);

      // alarm edit 12:00 AM -> 6:30 AM
      pInc(6); pMode(1); pInc(30); pMode(2);
      eAHr = 6; eAMin = 30; eAPm = 0;
      snap("alarm_written", 0, 0);
      press(0, 0, 0, 1);
      snap("alarm_on", 0, 1);
      pMode(1);
      snap("t_hr_alarm_on", 1, 1);
      pMode(2);
      commit(9, 45, 0);
      pMode(1);
      snap("a_hr_alarm_masked", 4, 0);
      pMode(3);
      snap("idle_alarm_restored", 0, 1);

      // hour wraps, inc+dec cancel, minute dec wrap, mode beats inc
      cs.cur_hours = 4'd12; cs.cur_minutes = 6'd0; cs.cur_pm = 1'b1;
      pMode(1); pInc(1); pDec(1); press(0, 1, 1, 0); pInc(1);
      pMode(1); pDec(1); pMode(1);
      commit(1, 59, 1);
      press(1, 1, 0, 0);
      snap("mode_wins", 4, 0);
      pMode(3);
      pInc(1);
      snap("idle_inc_ignored", 0, 1);

      // hour dec 1->12
      cs.cur_hours = 4'd1; cs.cur_minutes = 6'd5; cs.cur_pm = 1'b0;
      pMode(1); pDec(1); pMode(2);
      commit(12, 5, 0);
      pMode(1);
      snap("hr_dec_wrap", 4, 0);
      pMode(3);

      // alarm to 11:55 AM, then snooze while sounding
      pMode(3);
      commit(1, 5, 0);
      pMode(1);
      pInc(5); pMode(1); pInc(25); pMode(2);
      eAHr = 11; eAMin = 55; eAPm = 0;
      snap("alarm_1155", 0, 1);
      cs.alarm_sound = 1'b1;
      cs.snooze_btn = 1'b1;
      @(posedge clk); #1;
`ifdef CLOCK_SETTER_SNOOZE_EN
      eAHr = 12; eAMin = 4; eAPm = 1;
      snap("snooze_gap", 0, 0);
`else
      snap("snooze_ignored", 0, 1);
`endif
      cs.snooze_btn = 1'b0;
      @(posedge clk); #1;
      snap("snooze_after", 0, 1);
      cs.alarm_sound = 1'b0;

      // alarm_btn clears in IDLE, ignored while editing
      press(0, 0, 0, 1);
      snap("alarm_off", 0, 0);
      pMode(1);
      press(0, 0, 0, 1);
      snap("alarm_btn_editing", 1, 0);
      pMode(1);
      snap("in_t_min", 2, 0);

      // reset mid-edit with mode held through and after reset
      cs.mode_btn = 1'b1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      eSHr = 12; eSMin = 0; eSPm = 0;
      eAHr = 12; eAMin = 0; eAPm = 0;
      snap("reset_mid_edit", 0, 0);
      cs.mode_btn = 1'b0;
      @(posedge clk); #1;
      pMode(1);
      snap("post_reset_mode", 1, 0);

      repeat (2) @(posedge clk);
      #1 done = 1'b1;
   end
endmodule
